// File: rtl/reg2axi_pkg.sv
// Shared types and constants for the reg2axi AXI4-Lite command master.
package reg2axi_pkg;

    localparam int DATA_WIDTH = 32;
    localparam int STRB_WIDTH = DATA_WIDTH / 8;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        READ  = 2'd2,
        RESP  = 2'd3
    } state_t;

endpackage

// File: rtl/reg2axi.sv
// Single-outstanding command/response to AXI4-Lite master; every output is a flop.
// Optional sticky watchdog flag when REG2AXI_TIMEOUT_EN is defined.
module reg2axi
    import reg2axi_pkg::*;
#(
    parameter int AXI_ADDR_WIDTH = 4,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic                      m_axi_aclk,
    input  logic                      m_axi_aresetn,
    input  logic                      cmd_valid,
    output logic                      cmd_ready,
    input  logic                      cmd_write,
    input  logic [AXI_ADDR_WIDTH-3:0] cmd_addr,
    input  logic [DATA_WIDTH-1:0]     cmd_wdata,
    input  logic [STRB_WIDTH-1:0]     cmd_wstrb,
    output logic                      rsp_valid,
    input  logic                      rsp_ready,
    output logic [DATA_WIDTH-1:0]     rsp_rdata,
    output logic [1:0]                rsp_resp,
    output logic [AXI_ADDR_WIDTH-1:0] m_axi_awaddr,
    output logic [2:0]                m_axi_awprot,
    output logic                      m_axi_awvalid,
    input  logic                      m_axi_awready,
    output logic [DATA_WIDTH-1:0]     m_axi_wdata,
    output logic [STRB_WIDTH-1:0]     m_axi_wstrb,
    output logic                      m_axi_wvalid,
    input  logic                      m_axi_wready,
    input  logic [1:0]                m_axi_bresp,
    input  logic                      m_axi_bvalid,
    output logic                      m_axi_bready,
    output logic [AXI_ADDR_WIDTH-1:0] m_axi_araddr,
    output logic [2:0]                m_axi_arprot,
    output logic                      m_axi_arvalid,
    input  logic                      m_axi_arready,
    input  logic [DATA_WIDTH-1:0]     m_axi_rdata,
    input  logic [1:0]                m_axi_rresp,
    input  logic                      m_axi_rvalid,
`ifdef REG2AXI_TIMEOUT_EN
    output logic                      timeout,
`endif
    output logic                      m_axi_rready
);

    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be at least 1");
    end

    typedef struct packed {
        logic                      cmd_ready;
        logic [AXI_ADDR_WIDTH-1:0] awaddr;
        logic                      awvalid;
        logic [DATA_WIDTH-1:0]     wdata;
        logic [STRB_WIDTH-1:0]     wstrb;
        logic                      wvalid;
        logic                      bready;
        logic [AXI_ADDR_WIDTH-1:0] araddr;
        logic                      arvalid;
        logic                      rready;
        logic                      rsp_valid;
        logic [DATA_WIDTH-1:0]     rsp_rdata;
        logic [1:0]                rsp_resp;
    } regs_t;

    state_t state, state_d;
    regs_t  r, r_d;

    // NOTE: sequential state uses non-blocking assignments; reset clears every output flop.
    always_ff @(posedge m_axi_aclk or negedge m_axi_aresetn) begin
        if (!m_axi_aresetn) begin
            state <= IDLE;
            r     <= '0;
        end else begin
            state <= state_d;
            r     <= r_d;
        end
    end

    always_comb begin
        // NOTE: hold-current defaults first, so no path can infer a latch.
        state_d = state;
        r_d     = r;
        case (state)
            IDLE: begin
                r_d.cmd_ready = 1'b1;
                if (cmd_valid && r.cmd_ready) begin
                    r_d.cmd_ready = 1'b0;
                    if (cmd_write) begin
                        r_d.awaddr  = {cmd_addr, 2'b00};
                        r_d.wdata   = cmd_wdata;
                        r_d.wstrb   = cmd_wstrb;
                        r_d.awvalid = 1'b1;
                        r_d.wvalid  = 1'b1;
                        r_d.bready  = 1'b1;
                        state_d     = WRITE;
                    end else begin
                        r_d.araddr  = {cmd_addr, 2'b00};
                        r_d.arvalid = 1'b1;
                        r_d.rready  = 1'b1;
                        state_d     = READ;
                    end
                end
            end
            WRITE: begin
                if (r.awvalid && m_axi_awready) r_d.awvalid = 1'b0;
                if (r.wvalid && m_axi_wready)   r_d.wvalid  = 1'b0;
                // The response only counts once both address and data have gone out.
                if (m_axi_bvalid && r.bready && !r.awvalid && !r.wvalid) begin
                    r_d.rsp_resp  = m_axi_bresp;
                    r_d.rsp_rdata = '0;
                    r_d.bready    = 1'b0;
                    r_d.rsp_valid = 1'b1;
                    state_d       = RESP;
                end
            end
            READ: begin
                if (r.arvalid && m_axi_arready) r_d.arvalid = 1'b0;
                if (m_axi_rvalid && r.rready) begin
                    r_d.rsp_rdata = m_axi_rdata;
                    r_d.rsp_resp  = m_axi_rresp;
                    r_d.rready    = 1'b0;
                    r_d.rsp_valid = 1'b1;
                    state_d       = RESP;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    r_d.rsp_valid = 1'b0;
                    r_d.cmd_ready = 1'b1;
                    state_d       = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign cmd_ready     = r.cmd_ready;
    assign rsp_valid     = r.rsp_valid;
    assign rsp_rdata     = r.rsp_rdata;
    assign rsp_resp      = r.rsp_resp;
    assign m_axi_awaddr  = r.awaddr;
    assign m_axi_awprot  = 3'b000;
    assign m_axi_awvalid = r.awvalid;
    assign m_axi_wdata   = r.wdata;
    assign m_axi_wstrb   = r.wstrb;
    assign m_axi_wvalid  = r.wvalid;
    assign m_axi_bready  = r.bready;
    assign m_axi_araddr  = r.araddr;
    assign m_axi_arprot  = 3'b000;
    assign m_axi_arvalid = r.arvalid;
    assign m_axi_rready  = r.rready;

`ifdef REG2AXI_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] wd_cnt;
    logic             busy;

    assign busy = (state == WRITE) || (state == READ);

    // Observation only: the counter saturates and never disturbs the AXI handshakes.
    always_ff @(posedge m_axi_aclk or negedge m_axi_aresetn) begin
        if (!m_axi_aresetn) begin
            wd_cnt  <= '0;
            timeout <= 1'b0;
        end else begin
            if (state == IDLE) begin
                wd_cnt <= '0;
            end else if (busy && wd_cnt != CNT_MAX) begin
                wd_cnt <= wd_cnt + 1'b1;
            end
            if (busy && wd_cnt == CNT_LAST) timeout <= 1'b1;
        end
    end
`endif

endmodule
